// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a shadow digit bank
// that is committed to the displayed bank only at a frame boundary.
module seven_seg_scan_driver #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 100000,
  localparam int AW          = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  wr_blank,
  input  logic                  commit,
  output logic                  commit_pending,
  output logic                  frame_start,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef struct packed {
    logic [3:0] data;
    logic       dp;
    logic       blank;
  } digit_t;

  logic [CW-1:0] refresh_cnt;
  logic [AW-1:0] scan_idx;
  digit_t        shadow [NUM_DIGITS];
  digit_t        active [NUM_DIGITS];
  logic          tick;
  logic          wrap_tick;
  logic          addr_ok;

  assign tick      = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign wrap_tick = tick && (scan_idx == AW'(NUM_DIGITS - 1));
  assign addr_ok   = int'(wr_addr) < NUM_DIGITS;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Refresh timing and frame-boundary pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap_tick;
      if (tick) begin
        refresh_cnt <= '0;
        scan_idx    <= wrap_tick ? '0 : scan_idx + AW'(1);
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end
    end
  end

  // Digit banks. The copy reads pre-edge shadow, so a same-edge write is
  // visible only in shadow until the next commit.
  // NOTE: both banks are small register arrays, not RAM, so they are reset
  // explicitly to give a known all-zero display after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (wrap_tick && (commit_pending || commit)) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
        commit_pending <= 1'b0;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
      if (wr_en && addr_ok) shadow[wr_addr] <= '{wr_data, wr_dp, wr_blank};
    end
  end

  // Registered pin drivers, one cycle behind scan_idx/active.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (active[scan_idx].blank) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << scan_idx);
      seg <= hex7(active[scan_idx].data);
      dp  <= ~active[scan_idx].dp;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized and directed bench for seven_seg_scan_driver; two builds (4 and 3
// digits) share stimulus and are checked against a frame-arithmetic model.
module tb_seven_seg_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic       commit = 1'b0;

  logic       cp4, fs4, dp4, cp3, fs3, dp3;
  logic [3:0] an4;
  logic [2:0] an3;
  logic [6:0] seg4, seg3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(DIV)) dut4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .commit(commit), .commit_pending(cp4),
    .frame_start(fs4), .an(an4), .seg(seg4), .dp(dp4)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(3), .REFRESH_DIV(DIV)) dut3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_blank(wr_blank), .commit(commit), .commit_pending(cp3),
    .frame_start(fs3), .an(an3), .seg(seg3), .dp(dp3)
  );

  // Reference model: position in the scan is derived from the count of edges
  // since reset; index 0 is the 4-digit build, index 1 the 3-digit build.
  typedef struct {
    int data;
    bit dp;
    bit blank;
  } dig_t;

  logic [6:0] hex_tbl [16];
  dig_t sh [2][8];
  dig_t ac [2][8];
  bit   pend [2];
  int   k [2];
  int   e_an [2], e_seg [2], e_dp [2], e_fs [2], e_cp [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int u, input int n);
    int  per, cur;
    bit  wrap;
    dig_t d;
    per = DIV * n;
    if (reset) begin
      k[u] = 0;
      pend[u] = 0;
      for (int i = 0; i < 8; i++) begin
        sh[u][i] = '{0, 0, 0};
        ac[u][i] = '{0, 0, 0};
      end
      e_an[u] = (1 << n) - 1; e_seg[u] = 7'h7F; e_dp[u] = 1; e_fs[u] = 0;
    end else begin
      wrap = (k[u] % per) == per - 1;
      cur  = (k[u] / DIV) % n;
      d    = ac[u][cur];
      if (d.blank) begin
        e_an[u] = (1 << n) - 1; e_seg[u] = 7'h7F; e_dp[u] = 1;
      end else begin
        e_an[u]  = ((1 << n) - 1) & ~(1 << cur);
        e_seg[u] = hex_tbl[d.data];
        e_dp[u]  = d.dp ? 0 : 1;
      end
      e_fs[u] = wrap;
      if (wrap && (pend[u] || commit)) begin
        for (int i = 0; i < 8; i++) ac[u][i] = sh[u][i];
        pend[u] = 0;
      end else if (commit) begin
        pend[u] = 1;
      end
      if (wr_en && int'(wr_addr) < n) sh[u][wr_addr] = '{int'(wr_data), wr_dp, wr_blank};
      k[u]++;
    end
    e_cp[u] = pend[u];
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge,
  // then single-cycle strobes drop.
  task automatic step();
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 3);
    @(negedge clk);
    check("an4",  32'(an4),  32'(e_an[0]));
    check("seg4", 32'(seg4), 32'(e_seg[0]));
    check("dp4",  32'(dp4),  32'(e_dp[0]));
    check("fs4",  32'(fs4),  32'(e_fs[0]));
    check("cp4",  32'(cp4),  32'(e_cp[0]));
    check("an3",  32'(an3),  32'(e_an[1]));
    check("seg3", 32'(seg3), 32'(e_seg[1]));
    check("dp3",  32'(dp3),  32'(e_dp[1]));
    check("fs3",  32'(fs3),  32'(e_fs[1]));
    check("cp3",  32'(cp3),  32'(e_cp[1]));
    reset  = 1'b0;
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int addr, input int data, input bit dpv, input bit blank);
    wr_en = 1'b1; wr_addr = 2'(addr); wr_data = 4'(data); wr_dp = dpv; wr_blank = blank;
    step();
  endtask

  initial begin
    hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reset held for two edges, then plain scanning of the zero bank.
    @(negedge clk);
    reset = 1'b1; step();
    reset = 1'b1; step();
    run(20);

    // Digits 1..4, commit mid-frame, then watch the copy land at the wrap.
    for (int i = 0; i < 4; i++) write(i, i + 1, 1'b0, 1'b0);
    run(2);
    commit = 1'b1; step();
    run(40);

    // Shadow write without commit stays invisible for several frames.
    write(0, 15, 1'b0, 1'b0);
    run(48);

    // Commit on the wrap edge together with a write that must stay in shadow.
    while (k[0] % (DIV * 4) != DIV * 4 - 1) step();
    commit = 1'b1;
    write(1, 10, 1'b0, 1'b0);
    run(40);

    // Blanked digit 2 and lit decimal point on digit 1.
    write(2, 8, 1'b0, 1'b1);
    write(1, 0, 1'b1, 1'b0);
    commit = 1'b1; step();
    run(40);

    // Out-of-range address on the 3-digit build, then a commit aborted by reset.
    write(3, 9, 1'b1, 1'b0);
    commit = 1'b1; step();
    run(3);
    reset = 1'b1; step();
    run(20);

    // Randomized traffic with occasional commits and resets.
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      wr_blank = ($urandom_range(0, 5) == 0);
      commit   = ($urandom_range(0, 11) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Display-side consumer of hex digit values: accepts 4-bit digit writes into a shadow bank and time-multiplexes the digits onto a common-anode seven-segment display.
- Commits the shadow bank to the displayed bank only at a frame boundary, so multi-digit updates never tear.
- Sits between switch/digit-selection logic and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; must be ≥ 2. Bench uses 4.
- AW, $clog2(NUM_DIGITS), width of wr_addr; derived, do not override.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; one write per cycle while high.
- wr_addr  in  AW  digit index to write (0 = rightmost).
- wr_data  in  4  hex value 0x0..0xF.
- wr_dp  in  1  decimal point for that digit (1 = lit).
- wr_blank  in  1  1 = digit dark.
- commit  in  1  1-cycle request to copy shadow bank to active bank at next frame start.
- commit_pending  out  1  high from commit until the copy occurs.
- frame_start  out  1  1-cycle pulse when scan wraps to digit 0.
- an  out  NUM_DIGITS  anode enables, active-low.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset applies on a clk edge with reset=1.
  - Clears refresh counter, scan index, shadow and active banks (data=0, dp=0, blank=0), commit_pending and frame_start.
  - Forces an=all 1s, seg=7'h7F, dp=1.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - tick = (counter == REFRESH_DIV-1).
  - On tick, scan index increments; NUM_DIGITS-1 wraps to 0.
- frame_start is registered: it pulses in the cycle after the tick that wraps the index to 0.
- Writes: wr_en=1 with wr_addr < NUM_DIGITS updates shadow[wr_addr] = {wr_data, wr_dp, wr_blank} on that edge. wr_addr ≥ NUM_DIGITS is ignored silently.
- Commit:
  - commit=1 sets commit_pending.
  - On the tick that wraps the index to 0 with commit_pending (or commit) high, the active bank takes the shadow bank and commit_pending clears on the same edge.
  - The copy takes shadow contents from before that edge. A write on the same edge lands in shadow only.
  - commit while already pending: no extra effect.
  - commit coincident with the wrap tick: copies on that tick, and commit_pending never rises.
- Outputs are registered, with one cycle latency from index/active change.
  - an = ~(1 << idx).
  - seg = hex7(active[idx].data); dp = ~active[idx].dp.
  - If active[idx].blank: an = all 1s, seg = 7'h7F, dp = 1.
- hex7 table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-frame or with a commit pending: the pending commit is discarded, and scanning restarts at digit 0 with counter 0.
- Exactly one anode is low at any time, except for blanked digits and the reset cycle.

Test Plan:
- Reset (REFRESH_DIV=4, NUM_DIGITS=4): assert reset 2 cycles -> an=1111, seg=7F, dp=1. First cycle after release -> an=1110, seg=1000000. an steps 1101, 1011, 0111, 1110 every 4 cycles; frame_start pulses once per 16 cycles.
- Digits 1,2,3,4 written at addr 0..3 then commit mid-frame:
  - commit_pending stays high until the wrap tick; until then displayed digits stay 0.
  - After the copy, an=1110 shows seg=1111001 (1) and an=0111 shows seg=0011001 (4). commit_pending=0.
- Write without commit: addr0=F, no commit -> display unchanged over 3 full frames.
- Commit coincident with wrap tick -> commit_pending never rises, new values visible from digit 0 of that frame. Write addr1=A on the same edge -> A not shown until a later commit.
- Blank + dp: addr2 data=8, blank=1; addr1 data=0, dp=1; commit.
  - In the digit-2 slot: an=1111, seg=7F.
  - In the digit-1 slot: an=1101, seg=1000000, dp=0.
- Out-of-range and reset abort:
  - Build with NUM_DIGITS=3 and write addr=3 -> no shadow change.
  - Issue commit, assert reset before the wrap -> commit_pending=0, active bank all zero, scan restarts at an=110.
